// File: rtl/proc_pkg.sv
// Shared constants for proc and its instruction feeder: word width, opcode
// field placement, the immediate opcode, the halt word and the feeder states.
package proc_pkg;

    localparam int unsigned PROC_WIDTH   = 16;
    localparam int unsigned PROC_ADDR_W  = 5;
    localparam int unsigned PROC_TIMEOUT = 255;

    // Opcode occupies the top three bits of an instruction word.
    localparam int unsigned OPC_W   = 3;
    localparam int unsigned OPC_MSB = PROC_WIDTH - 1;
    localparam int unsigned OPC_LSB = PROC_WIDTH - OPC_W;

    localparam logic [OPC_W-1:0]      PROC_IMM_OPCODE = 3'b001;
    localparam logic [PROC_WIDTH-1:0] PROC_HALT_WORD  = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_FETCH_IMM,
        ST_WAIT,
        ST_HALTED
    } feeder_state_e;

endpackage

// File: rtl/prog_ram.sv
// Program RAM: one synchronous write port, one synchronous read port with
// a single cycle of read latency. Contents are not reset.
module prog_ram #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned WIDTH  = 16
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [0:(1 << ADDR_W) - 1];
    logic [WIDTH-1:0] rdata_q;

    // Write port.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read port.
    always_ff @(posedge clk_i) begin
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/proc_instr_feeder.sv
// Instruction feeder for proc: streams program RAM words onto DIN with a Run
// pulse, waits for Done, advances PC, supplies immediate operand words and
// halts on the halt word, a Done timeout, or after each instruction in step mode.
module proc_instr_feeder
    import proc_pkg::*;
#(
    parameter int unsigned      WIDTH      = PROC_WIDTH,
    parameter int unsigned      ADDR_W     = PROC_ADDR_W,
    parameter logic [OPC_W-1:0] IMM_OPCODE = PROC_IMM_OPCODE,
    parameter logic [WIDTH-1:0] HALT_WORD  = PROC_HALT_WORD,
    parameter int unsigned      TIMEOUT    = PROC_TIMEOUT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              step_i,
    input  logic              prog_we_i,
    input  logic [ADDR_W-1:0] prog_addr_i,
    input  logic [WIDTH-1:0]  prog_data_i,
    input  logic              done_i,
    output logic [WIDTH-1:0]  din_o,
    output logic              run_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic              busy_o,
    output logic              halted_o,
    output logic              err_o
);

    localparam int unsigned TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    feeder_state_e     state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [WIDTH-1:0]  din_q, din_d;
    logic              err_q, err_d;
    logic              imm_q, imm_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic              start_q;

    logic              start_edge;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_raddr;
    logic [WIDTH-1:0]  ram_rdata;
    logic              word_is_halt;
    logic              word_is_imm;

    assign start_edge   = start_i & ~start_q;
    assign word_is_halt = (ram_rdata == HALT_WORD);
    assign word_is_imm  = (ram_rdata[WIDTH-1 -: OPC_W] == IMM_OPCODE);

    assign busy_o   = (state_q == ST_FETCH) || (state_q == ST_ISSUE) ||
                      (state_q == ST_FETCH_IMM) || (state_q == ST_WAIT);
    assign halted_o = (state_q == ST_HALTED);
    assign err_o    = err_q;
    assign pc_o     = pc_q;

    // Program writes are locked out while an instruction is in flight.
    assign ram_we    = prog_we_i & ~busy_o;
    // ISSUE already fetches the operand slot so it is ready in FETCH_IMM.
    assign ram_raddr = (state_q == ST_ISSUE) ? pc_q + ADDR_W'(1) : pc_q;

    prog_ram #(
        .ADDR_W (ADDR_W),
        .WIDTH  (WIDTH)
    ) u_prog_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .waddr_i (prog_addr_i),
        .wdata_i (prog_data_i),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    // Run and the issued word come straight off the RAM output register
    // during ISSUE, so the instruction reaches proc in the same cycle it is
    // checked against the halt word; otherwise DIN holds the captured word.
    always_comb begin
        run_o = (state_q == ST_ISSUE) && !word_is_halt;
        din_o = run_o ? ram_rdata : din_q;
    end

    // State, PC, DIN, timer and error registers; start edge-detect flop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            din_q   <= '0;
            err_q   <= 1'b0;
            imm_q   <= 1'b0;
            timer_q <= '0;
            start_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            din_q   <= din_d;
            err_q   <= err_d;
            imm_q   <= imm_d;
            timer_q <= timer_d;
            start_q <= start_i;
        end
    end

    // Next-state logic for the fetch/issue/wait sequence.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        din_d   = din_q;
        err_d   = err_q;
        imm_d   = imm_q;
        timer_d = timer_q;
        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (word_is_halt) begin
                    state_d = ST_HALTED;
                end else begin
                    din_d   = ram_rdata;
                    imm_d   = word_is_imm;
                    timer_d = '0;
                    state_d = word_is_imm ? ST_FETCH_IMM : ST_WAIT;
                end
            end
            ST_FETCH_IMM: begin
                din_d   = ram_rdata;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (done_i) begin
                    pc_d    = pc_q + (imm_q ? ADDR_W'(2) : ADDR_W'(1));
                    state_d = step_i ? ST_IDLE : ST_FETCH;
                end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = ST_HALTED;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_HALTED: begin
                if (start_edge) begin
                    pc_d    = '0;
                    err_d   = 1'b0;
                    state_d = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_proc_instr_feeder.sv
// Self-checking bench for proc_instr_feeder: directed scenarios with random
// program words, Done delays and input noise, checked against a program-level
// model (memory image, PC, count of issued instructions).
module tb_proc_instr_feeder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        step = 1'b0;
    logic        prog_we = 1'b0;
    logic [4:0]  prog_addr = '0;
    logic [15:0] prog_data = '0;
    logic        done = 1'b0;
    logic [15:0] din;
    logic        run;
    logic [4:0]  pc;
    logic        busy;
    logic        halted;
    logic        err;

    int checks = 0;
    int errors = 0;

    // Model state
    logic [15:0] mem_m [32];
    int unsigned pc_m = 0;
    int unsigned issued_m = 0;
    int          run_cnt = 0;

    proc_instr_feeder #(
        .WIDTH   (16),
        .ADDR_W  (5),
        .TIMEOUT (255)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .step_i      (step),
        .prog_we_i   (prog_we),
        .prog_addr_i (prog_addr),
        .prog_data_i (prog_data),
        .done_i      (done),
        .din_o       (din),
        .run_o       (run),
        .pc_o        (pc),
        .busy_o      (busy),
        .halted_o    (halted),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    // Count Run pulses mid-cycle.
    always @(negedge clk) begin
        if (run) run_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        start = 1'b0; done = 1'b0; prog_we = 1'b0; step = 1'b0;
    endtask

    // Inputs that must be ignored while busy: Start, Done outside WAIT, Step, Prog_WE.
    task automatic noise(input bit en);
        if (en) begin
            start     = 1'($urandom);
            done      = 1'($urandom);
            step      = 1'($urandom);
            prog_we   = 1'($urandom);
            prog_addr = $urandom_range(0, 1) ? 5'd3 : 5'($urandom);
            prog_data = 16'($urandom);
        end else begin
            quiet();
        end
    endtask

    task automatic load(input logic [4:0] a, input logic [15:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        tick();
        prog_we = 1'b0;
        mem_m[a] = d;
    endtask

    task automatic pulse_start();
        quiet();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    function automatic logic [15:0] plain_word();
        logic [15:0] w;
        w = 16'($urandom) | 16'h0001;
        if (w[15:13] == 3'b001 || w == 16'hFFFF) w[15:13] = 3'b010;
        return w;
    endfunction

    function automatic logic [15:0] any_word();
        logic [15:0] w;
        if ($urandom_range(0, 1) == 1) w = {3'b001, 13'($urandom)};
        else w = plain_word();
        return w;
    endfunction

    // Runs one instruction starting in its FETCH cycle.
    task automatic exec_one(input int dly, input bit step_exit, input bit noisy, output bit halted_flag);
        logic [15:0] w;
        bit          imm;
        halted_flag = 1'b0;
        chk("fetch_busy", busy, 1);
        chk("fetch_run", run, 0);
        noise(noisy); tick();
        w = mem_m[pc_m];
        if (w == 16'hFFFF) begin
            chk("halt_run", run, 0);
            noise(noisy); tick();
            quiet();
            chk("halt_halted", halted, 1);
            chk("halt_busy", busy, 0);
            chk("halt_pc", pc, pc_m);
            halted_flag = 1'b1;
            return;
        end
        chk("issue_run", run, 1);
        chk("issue_din", din, w);
        issued_m++;
        imm = (w[15:13] == 3'b001);
        noise(noisy); tick();
        if (imm) begin
            chk("fimm_din", din, w);
            chk("fimm_run", run, 0);
            noise(noisy); tick();
            w = mem_m[(pc_m + 1) % 32];
        end
        for (int i = 0; i < dly; i++) begin
            chk("wait_din", din, w);
            noise(noisy); done = 1'b0; tick();
        end
        chk("wait_din", din, w);
        chk("wait_run", run, 0);
        noise(noisy); done = 1'b1; step = step_exit; start = 1'b0;
        tick();
        quiet();
        pc_m = (pc_m + (imm ? 2 : 1)) % 32;
        chk("done_pc", pc, pc_m);
        chk("done_busy", busy, !step_exit);
    endtask

    initial begin
        bit          h;
        bit          wrapped;
        logic [15:0] w;
        int unsigned nxt;

        // Reset, checked before any clock edge.
        #2 rst = 1'b1;
        #2;
        chk("rst_din", din, 0);
        chk("rst_run", run, 0);
        chk("rst_pc", pc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_halted", halted, 0);
        chk("rst_err", err, 0);
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        tick();

        // Single plain word then halt; Done on the third WAIT cycle.
        load(5'd0, 16'h0005);
        load(5'd1, 16'hFFFF);
        pc_m = 0;
        pulse_start();
        exec_one(2, 1'b0, 1'b0, h);
        exec_one(0, 1'b0, 1'b0, h);
        chk("t1_halted", halted, 1);
        chk("t1_runs", run_cnt, issued_m);

        // Immediate instruction: opcode word then operand held through WAIT.
        load(5'd0, 16'h2000);
        load(5'd1, 16'h00AB);
        load(5'd2, 16'hFFFF);
        pulse_start();
        pc_m = 0;
        exec_one($urandom_range(0, 5), 1'b0, 1'b0, h);
        exec_one(0, 1'b0, 1'b0, h);
        chk("t2_halted", halted, 1);
        chk("t2_pc", pc, 2);

        // Step mode with noisy inputs while busy (including writes to addr 3).
        for (int a = 0; a < 4; a++) load(5'(a), plain_word());
        load(5'd4, plain_word());
        pulse_start();
        pc_m = 0;
        for (int k = 0; k < 4; k++) begin
            exec_one($urandom_range(0, 4), 1'b1, 1'b1, h);
            chk("step_pc", pc, k + 1);
            chk("step_idle", busy, 0);
            if (k < 3) pulse_start();
        end
        // Rewriting the current PC slot while IDLE is picked up by the next fetch.
        load(5'd4, plain_word());
        pulse_start();
        exec_one(1, 1'b1, 1'b0, h);
        chk("rewrite_pc", pc, 5);

        // Asynchronous reset during WAIT.
        load(5'd5, plain_word());
        pulse_start();
        tick();
        issued_m++;
        tick();
        #3 rst = 1'b1;
        #1;
        chk("arst_run", run, 0);
        chk("arst_din", din, 0);
        chk("arst_pc", pc, 0);
        chk("arst_busy", busy, 0);
        @(posedge clk); #1 rst = 1'b0;
        pc_m = 0;

        // Done timeout: Halted and Err exactly 255 cycles into WAIT.
        load(5'd0, plain_word());
        pulse_start();
        tick();
        chk("to_run", run, 1);
        issued_m++;
        tick();
        repeat (254) tick();
        chk("to_early_halted", halted, 0);
        chk("to_early_busy", busy, 1);
        tick();
        chk("to_halted", halted, 1);
        chk("to_err", err, 1);
        chk("to_pc", pc, 0);
        pulse_start();
        pc_m = 0;
        chk("to_clr_err", err, 0);
        chk("to_clr_pc", pc, 0);
        exec_one(1, 1'b1, 1'b0, h);

        // Done on the timeout cycle wins.
        load(5'd1, plain_word());
        pulse_start();
        tick();
        issued_m++;
        tick();
        repeat (254) tick();
        done = 1'b1; step = 1'b1;
        tick();
        quiet();
        pc_m = 2;
        chk("tie_err", err, 0);
        chk("tie_halted", halted, 0);
        chk("tie_pc", pc, pc_m);

        // Random full-depth program run until PC wraps past 31.
        for (int a = 0; a < 32; a++) load(5'(a), any_word());
        load(5'd30, plain_word());
        load(5'd31, plain_word());
        pulse_start();
        wrapped = 1'b0;
        for (int n = 0; n < 40 && !wrapped; n++) begin
            w = mem_m[pc_m];
            nxt = pc_m + ((w[15:13] == 3'b001) ? 2 : 1);
            wrapped = (nxt >= 32);
            exec_one($urandom_range(0, 3), wrapped, 1'b1, h);
        end
        chk("wrap_pc", pc, 0);
        chk("wrap_idle", busy, 0);
        chk("final_runs", run_cnt, issued_m);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
